// File: rtl/ccff_chain_loader.sv
// Serializes a word-stream bitstream into a configuration flip-flop chain and
// returns the bits leaving the chain tail as readback words.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; bit_count holds the last load's total
// LOAD  | fetching words and shifting bits into the chain
// FLUSH | all bits shifted; draining the final readback word
// DONE  | one-cycle completion pulse
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 62,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_clk_en,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BL_W    = $clog2(WORD_W + 1);
    localparam int WF_W    = $clog2(N_WORDS + 1);
    localparam int PI_W    = $clog2(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [WORD_W-1:0] buf_q;
    logic [BL_W-1:0]   bits_left_q;
    logic [WF_W-1:0]   words_q;
    logic [CNT_W-1:0]  bit_count_q;
    logic [WORD_W-1:0] pack_q;
    logic [PI_W-1:0]   pack_idx_q;
    logic              pack_full_q;
    logic [WORD_W-1:0] out_data_q;
    logic              out_valid_q;

    logic              shift_en;
    logic              in_fire;
    logic              out_pop;
    logic              out_free;
    logic              last_shift;
    logic              word_done;
    logic [WORD_W-1:0] pack_mask;
    logic [WORD_W-1:0] pack_word;
    logic [31:0]       remaining;
    logic [BL_W-1:0]   fill;

    // Shift enable depends on registers only, so the gated chain clock never
    // sees a combinational path from either handshake input.
    assign shift_en   = (state_q == S_LOAD) && (bits_left_q != '0) && !pack_full_q;
    assign in_ready   = (state_q == S_LOAD) && (bits_left_q == '0) &&
                        (words_q < WF_W'(N_WORDS));
    assign in_fire    = in_ready && in_valid;
    assign out_pop    = out_valid_q && out_ready;
    assign out_free   = !out_valid_q || out_ready;
    assign last_shift = shift_en && (bit_count_q == CNT_W'(CHAIN_LEN - 1));
    assign word_done  = shift_en &&
                        ((pack_idx_q == PI_W'(WORD_W - 1)) || last_shift);

    // Tail bits fill the pack register from the MSB downward.
    assign pack_mask  = {1'b1, {(WORD_W-1){1'b0}}} >> pack_idx_q;
    assign pack_word  = ccff_tail ? (pack_q | pack_mask) : pack_q;

    // The final word only supplies as many bits as the chain still needs.
    assign remaining  = 32'(CHAIN_LEN) - 32'(bit_count_q);
    assign fill       = (remaining >= 32'(WORD_W)) ? BL_W'(WORD_W) : BL_W'(remaining);

    assign ccff_head   = buf_q[WORD_W-1];
    assign ccff_clk_en = shift_en;
    assign bit_count   = bit_count_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                // A held pack word means the word being popped is not the last one.
                if (!pack_full_q && out_pop) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            buf_q       <= '0;
            bits_left_q <= '0;
            words_q     <= '0;
            bit_count_q <= '0;
            pack_q      <= '0;
            pack_idx_q  <= '0;
            pack_full_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                buf_q       <= '0;
                bits_left_q <= '0;
                words_q     <= '0;
                bit_count_q <= '0;
                pack_q      <= '0;
                pack_idx_q  <= '0;
                pack_full_q <= 1'b0;
            end else begin
                if (in_fire) begin
                    buf_q       <= in_data;
                    bits_left_q <= fill;
                    words_q     <= words_q + 1'b1;
                end else if (shift_en) begin
                    buf_q       <= buf_q << 1;
                    bits_left_q <= bits_left_q - 1'b1;
                end

                if (shift_en) begin
                    bit_count_q <= bit_count_q + 1'b1;
                    if (word_done) begin
                        pack_q     <= '0;
                        pack_idx_q <= '0;
                        if (!out_free) begin
                            pack_q      <= pack_word;
                            pack_full_q <= 1'b1;
                        end
                    end else begin
                        pack_q     <= pack_word;
                        pack_idx_q <= pack_idx_q + 1'b1;
                    end
                end else if (pack_full_q && out_free) begin
                    pack_q      <= '0;
                    pack_full_q <= 1'b0;
                end
            end

            if (word_done && out_free) begin
                out_data_q  <= pack_word;
                out_valid_q <= 1'b1;
            end else if (pack_full_q && out_free) begin
                out_data_q  <= pack_q;
                out_valid_q <= 1'b1;
            end else if (out_pop) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 20-flop chain model behind the gated clock,
// scoreboard queues for head bits and readback words, plus a 1-flop instance.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        pReset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ccff_head;
    logic        ccff_tail;
    logic        ccff_clk_en;
    logic [4:0]  bit_count;

    logic        s_start = 1'b0;
    logic        s_busy;
    logic        s_done;
    logic [1:0]  s_in_data = 2'b00;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [1:0]  s_out_data;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic        s_head;
    logic        s_tail;
    logic        s_clk_en;
    logic [0:0]  s_bit_count;

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_clk_en(ccff_clk_en),
        .bit_count(bit_count)
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(2)) dut_small (
        .prog_clk(prog_clk), .pReset(pReset), .start(s_start), .busy(s_busy), .done(s_done),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .ccff_head(s_head), .ccff_tail(s_tail), .ccff_clk_en(s_clk_en),
        .bit_count(s_bit_count)
    );

    // Chain bit 19 is the flop at the tail; this image reads back as F0 F5 A0.
    localparam logic [19:0] CHAIN_INIT = 20'hF0F5A;
    localparam logic [19:0] LOAD_IMG   = 20'h3C96E;

    logic [19:0] chain = '0;
    int          shift_cnt = 0;
    logic        preload_req = 1'b0;
    logic        s_chain = 1'b0;
    logic        s_preload = 1'b0;
    int          cyc = 0;

    always @(posedge prog_clk) begin
        cyc <= cyc + 1;
        if (preload_req) begin
            chain     <= CHAIN_INIT;
            shift_cnt <= 0;
        end else if (ccff_clk_en) begin
            chain     <= {chain[18:0], ccff_head};
            shift_cnt <= shift_cnt + 1;
        end
        if (s_preload) begin
            s_chain <= 1'b1;
        end else if (s_clk_en) begin
            s_chain <= s_head;
        end
    end

    assign ccff_tail = chain[19];
    assign s_tail    = s_chain;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    bit          exp_head[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  words[3] = '{8'h3C, 8'h96, 8'hE7};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    always @(negedge prog_clk) begin : mon
        logic [31:0] e;
        if (ccff_clk_en) begin
            e = (exp_head.size() > 0) ? 32'(exp_head.pop_front()) : 32'hDEAD_BEEF;
            chk("head_bit", 32'(ccff_head), e);
        end
        if (out_valid && out_ready) begin
            e = (exp_rd.size() > 0) ? 32'(exp_rd.pop_front()) : 32'hDEAD_BEEF;
            chk("readback_word", 32'(out_data), e);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 0);
            chk("count_at_done", 32'(bit_count), 20);
        end
    end

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_in_ready"}, 32'(in_ready), 0);
        chk({pfx, "_out_valid"}, 32'(out_valid), 0);
        chk({pfx, "_out_data"}, 32'(out_data), 0);
        chk({pfx, "_head"}, 32'(ccff_head), 0);
        chk({pfx, "_clk_en"}, 32'(ccff_clk_en), 0);
        chk({pfx, "_bit_count"}, 32'(bit_count), 0);
    endtask

    task automatic run_load(input bit rand_valid, input int ready_at, input int abort_at,
                            input bit poke_start);
        int         widx;
        bit         xfer;
        bit         finished;
        int         base_done;
        logic [7:0] w;
        widx      = 0;
        xfer      = 1'b0;
        finished  = 1'b0;
        base_done = done_cnt;
        preload_req = 1'b1;
        step();
        preload_req = 1'b0;
        exp_head.delete();
        exp_rd.delete();
        for (int i = 0; i < 20; i++) begin
            w = words[i / 8];
            exp_head.push_back(w[7 - (i % 8)]);
        end
        exp_rd.push_back(8'hF0);
        exp_rd.push_back(8'hF5);
        exp_rd.push_back(8'hA0);
        out_ready = (ready_at == 0);
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("in_ready_after_start", 32'(in_ready), 1);
        for (int c = 1; c < 300 && !finished; c++) begin
            if (xfer) begin
                widx++;
                if (ready_at == 0) begin
                    w = words[widx - 1];
                    chk("clk_en_after_xfer", 32'(ccff_clk_en), 1);
                    chk("head_after_xfer", 32'(ccff_head), 32'(w[7]));
                end
            end
            if (abort_at > 0 && shift_cnt == abort_at) begin
                in_valid = 1'b0;
                pReset   = 1'b1;
                step();
                pReset = 1'b0;
                check_reset_outputs("abort");
                repeat (5) step();
                chk("no_done_after_reset", 32'(done_cnt - base_done), 0);
                exp_head.delete();
                exp_rd.delete();
                finished = 1'b1;
            end else if (done) begin
                start    = poke_start;
                in_valid = 1'b0;
                step();
                start    = 1'b0;
                finished = 1'b1;
            end else begin
                if (ready_at > 0 && c == ready_at) begin
                    chk("stall_shift_count", 32'(shift_cnt), 16);
                    chk("stall_clk_en", 32'(ccff_clk_en), 0);
                    chk("stall_out_valid", 32'(out_valid), 1);
                end
                in_valid  = (widx < 3) && (!rand_valid || ($urandom_range(0, 1) == 1));
                in_data   = (widx < 3) ? words[widx] : 8'h00;
                out_ready = (c >= ready_at);
                start     = poke_start && (c == 5);
                xfer      = in_valid && in_ready;
                step();
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("load_finished", 32'(finished), 1);
        if (abort_at == 0) begin
            repeat (3) step();
            chk("done_pulses", 32'(done_cnt - base_done), 1);
            chk("total_shifts", 32'(shift_cnt), 20);
            chk("chain_contents", 32'(chain), 32'(LOAD_IMG));
            chk("readback_left", 32'(exp_rd.size()), 0);
            chk("head_bits_left", 32'(exp_head.size()), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("bit_count_hold", 32'(bit_count), 20);
            chk("out_valid_idle", 32'(out_valid), 0);
            if (!rand_valid && ready_at == 0) begin
                chk("done_latency", 32'(done_cyc - start_cyc), 25);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pReset = 1'b1;
        repeat (3) step();
        pReset = 1'b0;
        check_reset_outputs("reset");
        chk("small_reset_busy", 32'(s_busy), 0);
        chk("small_reset_out_valid", 32'(s_out_valid), 0);
        step();

        run_load(1'b0, 0, 0, 1'b0);
        run_load(1'b1, 0, 0, 1'b0);
        run_load(1'b0, 30, 0, 1'b0);
        run_load(1'b0, 0, 11, 1'b0);
        run_load(1'b0, 0, 0, 1'b0);
        run_load(1'b0, 0, 0, 1'b1);

        s_preload = 1'b1;
        step();
        s_preload   = 1'b0;
        s_out_ready = 1'b1;
        s_start     = 1'b1;
        step();
        s_start = 1'b0;
        chk("small_busy", 32'(s_busy), 1);
        chk("small_in_ready", 32'(s_in_ready), 1);
        s_in_valid = 1'b1;
        s_in_data  = 2'b10;
        step();
        s_in_valid = 1'b0;
        chk("small_clk_en", 32'(s_clk_en), 1);
        chk("small_head", 32'(s_head), 1);
        chk("small_in_ready_after", 32'(s_in_ready), 0);
        step();
        chk("small_out_valid", 32'(s_out_valid), 1);
        chk("small_out_data", 32'(s_out_data), 32'h2);
        chk("small_done_early", 32'(s_done), 0);
        chk("small_clk_en_off", 32'(s_clk_en), 0);
        step();
        chk("small_done", 32'(s_done), 1);
        chk("small_busy_at_done", 32'(s_busy), 0);
        chk("small_bit_count", 32'(s_bit_count), 1);
        chk("small_out_popped", 32'(s_out_valid), 0);
        step();
        chk("small_done_pulse", 32'(s_done), 0);
        chk("small_chain", 32'(s_chain), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
